// File: rtl/eks_scheduler_pkg.sv
// Shared types and constants for the bcrypt EksBlowfishSetup / final-encrypt sequencer.
package bcrypt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_INIT_ISSUE = 4'd1,
        ST_INIT_WAIT  = 4'd2,
        ST_KEY_ISSUE  = 4'd3,
        ST_KEY_WAIT   = 4'd4,
        ST_SALT_ISSUE = 4'd5,
        ST_SALT_WAIT  = 4'd6,
        ST_ENC_ISSUE  = 4'd7,
        ST_ENC_WAIT   = 4'd8,
        ST_DONE       = 4'd9
    } eks_state_t;

    typedef enum logic [1:0] {
        EK_KEY_SALT  = 2'd0,
        EK_KEY_ZERO  = 2'd1,
        EK_SALT_ZERO = 2'd2
    } ek_mode_t;

    // "OrpheanBeholderScryDoubt"
    localparam logic [191:0] BCRYPT_CTEXT =
        192'h4f727068_65616e42_65686f6c_64657253_63727944_6f756274;

    localparam logic [4:0] BCRYPT_MIN_COST = 5'd4;

    // Word idx of the magic value, word 0 being the most significant.
    function automatic logic [31:0] ctext_word(input logic [191:0] v, input int idx);
        return v[191 - 32 * idx -: 32];
    endfunction

endpackage

// File: rtl/eks_scheduler_if.sv
// Handshake bundle between the scheduler (master) and the expand-key / encipher engines (slave).
interface eks_scheduler_if;
    logic        ek_start;
    logic [1:0]  ek_mode;
    logic        ek_done;
    logic        enc_start;
    logic [31:0] enc_L;
    logic [31:0] enc_R;
    logic        enc_done;
    logic [31:0] enc_resultL;
    logic [31:0] enc_resultR;

    modport master (
        output ek_start, ek_mode, enc_start, enc_L, enc_R,
        input  ek_done, enc_done, enc_resultL, enc_resultR
    );

    modport slave (
        input  ek_start, ek_mode, enc_start, enc_L, enc_R,
        output ek_done, enc_done, enc_resultL, enc_resultR
    );
endinterface

// File: rtl/eks_iter_counter.sv
// Key-schedule iteration counter; last flags the final KEY/SALT pair for 2^cost iterations.
module eks_iter_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    input  logic [4:0] cost,
    output logic       last
);
    logic [32:0] count_r;

    // Iteration count, cleared at run start and stepped per completed SALT pass
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= 33'd0;
        end else if (clear) begin
            count_r <= 33'd0;
        end else if (inc) begin
            count_r <= count_r + 33'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // True while the pass in flight is the last one for this cost
    always_comb begin
        last = ((count_r + 33'd1) == (33'd1 << cost));
    end
endmodule

// File: rtl/eks_scheduler.sv
// bcrypt EksBlowfishSetup + final encrypt sequencer. Optional cost floor: define EKS_COST_CHECK_EN.
module eks_scheduler
    import bcrypt_pkg::*;
#(
    parameter int CTEXT_WORDS = 6,
    parameter int ENC_ROUNDS  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [4:0]                cost,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [32*CTEXT_WORDS-1:0] hash,
    eks_scheduler_if.master           eng
);
    localparam int BLOCKS = CTEXT_WORDS / 2;
    localparam int BLK_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int RND_W  = (ENC_ROUNDS > 1) ? $clog2(ENC_ROUNDS) : 1;
    localparam int WIDX_W = $clog2(CTEXT_WORDS);
    localparam int HASH_W = 32 * CTEXT_WORDS;

    eks_state_t              state_r;
    logic [4:0]              cost_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;
    logic                    ek_start_r;
    ek_mode_t                ek_mode_r;
    logic                    enc_start_r;
    logic [31:0]             enc_l_r;
    logic [31:0]             enc_r_r;
    logic [HASH_W-1:0]       hash_r;
    logic [31:0]             ctext_r [CTEXT_WORDS];
    logic [RND_W-1:0]        round_cnt_r;
    logic [BLK_W-1:0]        blk_idx_r;

    logic                    cost_ok_s;
    logic                    accept_s;
    logic                    ek_ack_s;
    logic                    enc_ack_s;
    logic                    iter_inc_s;
    logic                    iter_last_s;
    logic [WIDX_W-1:0]       word_lo_s;
    logic [WIDX_W-1:0]       word_hi_s;
    logic [HASH_W-1:0]       ctext_flat_s;

    eks_iter_counter u_iter (
        .clk   (clk),
        .reset (reset),
        .clear (accept_s),
        .inc   (iter_inc_s),
        .cost  (cost_r),
        .last  (iter_last_s)
    );

    // Handshake qualification; a done coinciding with our own start pulse is too early to honour
    always_comb begin
`ifdef EKS_COST_CHECK_EN
        cost_ok_s = (cost >= BCRYPT_MIN_COST);
`else
        cost_ok_s = 1'b1;
`endif
        accept_s   = (state_r == ST_IDLE) && start && cost_ok_s;
        ek_ack_s   = eng.ek_done && !ek_start_r;
        enc_ack_s  = eng.enc_done && !enc_start_r;
        iter_inc_s = (state_r == ST_SALT_WAIT) && ek_ack_s;
        word_lo_s  = WIDX_W'({blk_idx_r, 1'b0});
        word_hi_s  = word_lo_s + WIDX_W'(1);
    end

    // Flatten the working ciphertext, word 0 in the MSBs
    always_comb begin
        ctext_flat_s = '0;
        for (int i = 0; i < CTEXT_WORDS; i++) begin
            ctext_flat_s[32 * (CTEXT_WORDS - 1 - i) +: 32] = ctext_r[i];
        end
    end

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cost_r      <= 5'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            ek_start_r  <= 1'b0;
            ek_mode_r   <= EK_KEY_SALT;
            enc_start_r <= 1'b0;
            enc_l_r     <= 32'd0;
            enc_r_r     <= 32'd0;
            hash_r      <= '0;
            round_cnt_r <= '0;
            blk_idx_r   <= '0;
            for (int i = 0; i < CTEXT_WORDS; i++) begin
                ctext_r[i] <= 32'd0;
            end
        end else begin
            ek_start_r  <= 1'b0;
            enc_start_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cost_r      <= cost;
                        busy_r      <= 1'b1;
                        round_cnt_r <= '0;
                        blk_idx_r   <= '0;
                        for (int i = 0; i < CTEXT_WORDS; i++) begin
                            ctext_r[i] <= ctext_word(BCRYPT_CTEXT, i);
                        end
                        state_r <= ST_INIT_ISSUE;
                    end else begin
                        err_r <= start;
                    end
                end
                ST_INIT_ISSUE: begin
                    ek_start_r <= 1'b1;
                    ek_mode_r  <= EK_KEY_SALT;
                    state_r    <= ST_INIT_WAIT;
                end
                ST_INIT_WAIT: begin
                    if (ek_ack_s) state_r <= ST_KEY_ISSUE;
                end
                ST_KEY_ISSUE: begin
                    ek_start_r <= 1'b1;
                    ek_mode_r  <= EK_KEY_ZERO;
                    state_r    <= ST_KEY_WAIT;
                end
                ST_KEY_WAIT: begin
                    if (ek_ack_s) state_r <= ST_SALT_ISSUE;
                end
                ST_SALT_ISSUE: begin
                    ek_start_r <= 1'b1;
                    ek_mode_r  <= EK_SALT_ZERO;
                    state_r    <= ST_SALT_WAIT;
                end
                ST_SALT_WAIT: begin
                    if (ek_ack_s) begin
                        state_r <= iter_last_s ? ST_ENC_ISSUE : ST_KEY_ISSUE;
                    end
                end
                ST_ENC_ISSUE: begin
                    enc_l_r     <= ctext_r[word_lo_s];
                    enc_r_r     <= ctext_r[word_hi_s];
                    enc_start_r <= 1'b1;
                    state_r     <= ST_ENC_WAIT;
                end
                ST_ENC_WAIT: begin
                    if (enc_ack_s) begin
                        ctext_r[word_lo_s] <= eng.enc_resultL;
                        ctext_r[word_hi_s] <= eng.enc_resultR;
                        // Block-major inside each round
                        if (blk_idx_r == BLK_W'(BLOCKS - 1)) begin
                            blk_idx_r <= '0;
                            if (round_cnt_r == RND_W'(ENC_ROUNDS - 1)) begin
                                state_r <= ST_DONE;
                            end else begin
                                round_cnt_r <= round_cnt_r + RND_W'(1);
                                state_r     <= ST_ENC_ISSUE;
                            end
                        end else begin
                            blk_idx_r <= blk_idx_r + BLK_W'(1);
                            state_r   <= ST_ENC_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    hash_r  <= ctext_flat_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign hash          = hash_r;
    assign eng.ek_start  = ek_start_r;
    assign eng.ek_mode   = ek_mode_r;
    assign eng.enc_start = enc_start_r;
    assign eng.enc_L     = enc_l_r;
    assign eng.enc_R     = enc_r_r;
endmodule

// File: tb/tb_eks_scheduler.sv
// Directed bench for eks_scheduler with stub engines answering 3 cycles after each start.
module tb_eks_scheduler;
    import bcrypt_pkg::*;

    logic         clk;
    logic         reset;
    logic         start;
    logic [4:0]   cost;
    logic         busy;
    logic         done;
    logic         err;
    logic [191:0] hash;

    eks_scheduler_if eif ();

    eks_scheduler #(.CTEXT_WORDS(6), .ENC_ROUNDS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .cost  (cost),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .hash  (hash),
        .eng   (eif)
    );

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;
    int ek_starts = 0;
    int enc_starts = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int ek_cnt    = 0;
    int enc_cnt   = 0;
    int pend_blk  = 0;
    int enc_idx   = 0;
    int run_ek_base = 0;
    int run_enc_base = 0;
    int start_cyc = 0;
    int first_ek_cyc = 0;
    int last_enc_done_cyc = 0;
    int done_cyc  = 0;
    int ek_at_first_enc = 0;
    int snap      = 0;
    logic [31:0]  pend_l;
    logic [31:0]  pend_r;
    logic         spur_ek = 1'b0;
    logic [1:0]   mode_q [$];
    logic [191:0] hash_q [$];
    logic [31:0]  model [6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the falling edge, run the engine stubs, observe and score DUT outputs
    task automatic tick();
        logic [1:0]   exp_mode;
        logic [191:0] exp_hash;
        int b;
        @(negedge clk);
        cyc++;
        eif.ek_done  = 1'b0;
        eif.enc_done = 1'b0;
        if (!reset) begin
            ek_cnt  = 0;
            enc_cnt = 0;
        end
        if (ek_cnt > 0) begin
            ek_cnt--;
            if (ek_cnt == 0) eif.ek_done = 1'b1;
        end
        if (enc_cnt > 0) begin
            enc_cnt--;
            if (enc_cnt == 0) begin
                eif.enc_done    = 1'b1;
                eif.enc_resultL = pend_r;
                eif.enc_resultR = pend_l;
                model[2 * pend_blk]     = pend_r;
                model[2 * pend_blk + 1] = pend_l;
                last_enc_done_cyc = cyc;
            end
        end
        if (spur_ek) eif.ek_done = 1'b1;
        if (eif.ek_start === 1'b1) begin
            ek_starts++;
            if (ek_starts - run_ek_base == 1) first_ek_cyc = cyc;
            exp_mode = (mode_q.size() > 0) ? mode_q.pop_front() : 2'd3;
            chk("ek_mode", 192'(eif.ek_mode), 192'(exp_mode));
            ek_cnt = 3;
        end
        if (eif.enc_start === 1'b1) begin
            b = enc_idx % 3;
            if (enc_idx == 0) ek_at_first_enc = ek_starts - run_ek_base;
            chk("enc_L", 192'(eif.enc_L), 192'(model[2 * b]));
            chk("enc_R", 192'(eif.enc_R), 192'(model[2 * b + 1]));
            enc_idx++;
            enc_starts++;
            pend_l   = eif.enc_L;
            pend_r   = eif.enc_R;
            pend_blk = b;
            enc_cnt  = 3;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            exp_hash = (hash_q.size() > 0) ? hash_q.pop_front() : {192{1'b1}};
            chk("hash", hash, exp_hash);
        end
        if (err === 1'b1) err_cnt++;
    endtask

    // Push the expected pass sequence and result, then pulse start
    task automatic launch(input logic [4:0] c);
        mode_q.push_back(2'd0);
        for (int i = 0; i < (1 << c); i++) begin
            mode_q.push_back(2'd1);
            mode_q.push_back(2'd2);
        end
        hash_q.push_back(BCRYPT_CTEXT);
        for (int i = 0; i < 6; i++) model[i] = BCRYPT_CTEXT[191 - 32 * i -: 32];
        enc_idx      = 0;
        run_ek_base  = ek_starts;
        run_enc_base = enc_starts;
        start_cyc    = cyc;
        ek_at_first_enc = -1;
        start = 1'b1;
        cost  = c;
        tick();
        start = 1'b0;
        cost  = 5'd31;
        chk("busy_after_start", 192'(busy), 192'(1'b1));
    endtask

    task automatic wait_ek(input int n);
        int k = 0;
        while ((ek_starts - run_ek_base) < n && k < 5000) begin tick(); k++; end
        chk("wait_ek", 192'((ek_starts - run_ek_base) >= n), 192'(1'b1));
    endtask

    task automatic wait_enc(input int n);
        int k = 0;
        while ((enc_starts - run_enc_base) < n && k < 5000) begin tick(); k++; end
        chk("wait_enc", 192'((enc_starts - run_enc_base) >= n), 192'(1'b1));
    endtask

    task automatic finish_run(input int exp_ek);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < 20000) begin tick(); k++; end
        chk("done_once", 192'(done_cnt - d0), 192'(1));
        chk("ek_count", 192'(ek_starts - run_ek_base), 192'(exp_ek));
        chk("enc_count", 192'(enc_starts - run_enc_base), 192'(192));
        chk("start_to_ek", 192'(first_ek_cyc - start_cyc), 192'(2));
        chk("encdone_to_done", 192'(done_cyc - last_enc_done_cyc), 192'(2));
        chk("busy_at_done", 192'(busy), 192'(1'b0));
        tick();
        chk("hash_held", hash, BCRYPT_CTEXT);
    endtask

    task automatic check_all_zero();
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_done", 192'(done), 192'(0));
        chk("rst_err", 192'(err), 192'(0));
        chk("rst_hash", hash, 192'(0));
        chk("rst_ek_start", 192'(eif.ek_start), 192'(0));
        chk("rst_ek_mode", 192'(eif.ek_mode), 192'(0));
        chk("rst_enc_start", 192'(eif.enc_start), 192'(0));
        chk("rst_enc_L", 192'(eif.enc_L), 192'(0));
        chk("rst_enc_R", 192'(eif.enc_R), 192'(0));
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        cost  = 5'd0;
        eif.ek_done     = 1'b0;
        eif.enc_done    = 1'b0;
        eif.enc_resultL = 32'd0;
        eif.enc_resultR = 32'd0;
        repeat (3) tick();
        check_all_zero();
        reset = 1'b1;
        tick();

        // Spurious ek_done while idle
        snap = ek_starts;
        spur_ek = 1'b1;
        tick();
        spur_ek = 1'b0;
        repeat (4) tick();
        chk("spur_idle_busy", 192'(busy), 192'(0));
        chk("spur_idle_ek", 192'(ek_starts - snap), 192'(0));

        // Full cost=4 run, with a spurious ek_done during ENC_WAIT
        launch(5'd4);
        wait_enc(5);
        spur_ek = 1'b1;
        tick();
        spur_ek = 1'b0;
        finish_run(33);

`ifdef EKS_COST_CHECK_EN
        snap = ek_starts;
        start = 1'b1;
        cost  = 5'd3;
        tick();
        start = 1'b0;
        chk("reject_err", 192'(err), 192'(1'b1));
        chk("reject_busy", 192'(busy), 192'(1'b0));
        repeat (8) tick();
        chk("reject_no_ek", 192'(ek_starts - snap), 192'(0));
        chk("reject_busy_late", 192'(busy), 192'(1'b0));
`else
        launch(5'd0);
        finish_run(3);
        chk("ek_before_enc", 192'(ek_at_first_enc), 192'(3));
`endif

        // Second start (cost=10) during KEY_WAIT is ignored
        launch(5'd4);
        wait_ek(2);
        start = 1'b1;
        cost  = 5'd10;
        tick();
        start = 1'b0;
        finish_run(33);

        // Reset during ENC_WAIT of round 20, then a clean run
        launch(5'd4);
        wait_enc(61);
        reset = 1'b0;
        tick();
        check_all_zero();
        reset = 1'b1;
        mode_q.delete();
        hash_q.delete();
        tick();
        launch(5'd4);
        finish_run(33);

`ifndef EKS_COST_CHECK_EN
        chk("err_never", 192'(err_cnt), 192'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
